sync_fifo_flex: RTL and testbench

//  Single-clock parametrised FIFO: next generation of the MAC buffering FIFOs for same-domain paths (e.g. TX frame staging).

---
 rtl/sync_fifo_flex.sv | 117 +++++++++++
 tb/tb_sync_fifo_flex.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock parametrised FIFO for same-domain buffering paths
// such as TX frame staging.
//
// There are two read modes. The standard mode has a registered read with one
// cycle of latency. The first-word-fall-through mode shows the head word
// combinationally. The block also provides an occupancy count, programmable
// almost-full and almost-empty flags, and sticky overflow and underflow flags
// that software can clear. Storage is a register array that is not reset.
//
// Ports
//   clk           clock, all logic on the rising edge
//   arst          asynchronous reset, active-high
//   w_en          write request
//   data_in       write data, sampled with w_en
//   r_en          read request (in FWFT mode, the acknowledge of the head word)
//   data_out      read data
//   full          count == SIZE
//   empty         count == 0
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         number of stored words, 0..SIZE
//   overflow      sticky: a write was attempted while full
//   underflow     sticky: a read was attempted while empty
//   clr_err       synchronous clear of overflow and underflow
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 8,
  parameter int PTR_LEN   = $clog2(SIZE),
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = SIZE - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               w_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               r_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [PTR_LEN:0]   count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);

  localparam logic [PTR_LEN:0] ONE   = {{PTR_LEN{1'b0}}, 1'b1};
  localparam logic [PTR_LEN:0] AF_TH = (PTR_LEN+1)'(AFULL_TH);
  localparam logic [PTR_LEN:0] AE_TH = (PTR_LEN+1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [SIZE];
  logic [PTR_LEN:0] wr_ptr;
  logic [PTR_LEN:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // The extra wrap bit tells full apart from empty when the low bits match.
  assign full  = (wr_ptr[PTR_LEN] != rd_ptr[PTR_LEN]) &&
                 (wr_ptr[PTR_LEN-1:0] == rd_ptr[PTR_LEN-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle beats the clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  // Both flags decode only the registered count, so they cannot glitch on the inputs.
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[PTR_LEN-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr[PTR_LEN-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] data_q;
      always_ff @(posedge clk or posedge arst) begin
        if (arst)        data_q <= '0;
        else if (rd_acc) data_q <= mem[rd_ptr[PTR_LEN-1:0]];
      end
      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex. It exercises three instances:
//   ua: standard read mode, default thresholds (almost_full >= 6, almost_empty <= 2)
//   ub: first-word-fall-through mode
//   uc: standard read mode, AFULL_TH=5, AEMPTY_TH=1
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic       w_a = 0, r_a = 0, c_a = 0;
  logic [7:0] d_a = 0;
  logic [7:0] q_a;
  logic [3:0] cnt_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;

  logic       w_b = 0, r_b = 0, c_b = 0;
  logic [7:0] d_b = 0;
  logic [7:0] q_b;
  logic [3:0] cnt_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

  logic       w_c = 0, r_c = 0, c_c = 0;
  logic [7:0] d_c = 0;
  logic [7:0] q_c;
  logic [3:0] cnt_c;
  logic       full_c, empty_c, af_c, ae_c, ovf_c, unf_c;

  sync_fifo_flex #(.WIDTH(8), .SIZE(8), .FWFT(0)) ua (
    .clk(clk), .arst(arst), .w_en(w_a), .data_in(d_a), .r_en(r_a), .data_out(q_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(cnt_a), .overflow(ovf_a), .underflow(unf_a), .clr_err(c_a));

  sync_fifo_flex #(.WIDTH(8), .SIZE(8), .FWFT(1)) ub (
    .clk(clk), .arst(arst), .w_en(w_b), .data_in(d_b), .r_en(r_b), .data_out(q_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(cnt_b), .overflow(ovf_b), .underflow(unf_b), .clr_err(c_b));

  sync_fifo_flex #(.WIDTH(8), .SIZE(8), .FWFT(0), .AFULL_TH(5), .AEMPTY_TH(1)) uc (
    .clk(clk), .arst(arst), .w_en(w_c), .data_in(d_c), .r_en(r_c), .data_out(q_c),
    .full(full_c), .empty(empty_c), .almost_full(af_c), .almost_empty(ae_c),
    .count(cnt_c), .overflow(ovf_c), .underflow(unf_c), .clr_err(c_c));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       w;
    logic       r;
    logic       clr;
    logic [7:0] d;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic w, input logic r, input logic clr, input logic [7:0] d,
                     input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.w = w; v.r = r; v.clr = clr; v.d = d; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic chk_rst(input string nm, input logic [3:0] cnt, input logic fu, input logic em,
                         input logic af, input logic ae, input logic ov, input logic un,
                         input logic [7:0] q);
    check({nm, " rst count"},   32'(cnt), 32'd0);
    check({nm, " rst full"},    32'(fu),  32'd0);
    check({nm, " rst empty"},   32'(em),  32'd1);
    check({nm, " rst afull"},   32'(af),  32'd0);
    check({nm, " rst aempty"},  32'(ae),  32'd1);
    check({nm, " rst ovf"},     32'(ov),  32'd0);
    check({nm, " rst unf"},     32'(un),  32'd0);
    check({nm, " rst dout"},    32'(q),   32'd0);
  endtask

  initial begin
    int         m_cnt;
    logic       wa, ra;
    logic [7:0] exp_d;

    // Vector table for ua. Expected count and sticky flags are worked out by hand.
    add(0, 1, 0, 8'h00, 0, 0, 1);              // read while empty
    add(0, 0, 1, 8'h00, 0, 0, 0);              // clear
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 8'(k), k, 0, 0);
    add(1, 0, 0, 8'hAA, 8, 1, 0);              // write while full, rejected
    add(0, 0, 1, 8'h00, 8, 0, 0);
    add(1, 0, 1, 8'hAB, 8, 1, 0);              // set beats clear
    add(0, 0, 1, 8'h00, 8, 0, 0);
    add(1, 1, 0, 8'hBB, 7, 1, 0);              // both while full
    add(0, 0, 1, 8'h00, 7, 0, 0);
    for (int k = 6; k >= 0; k--) add(0, 1, 0, 8'h00, k, 0, 0);
    add(1, 1, 0, 8'hC1, 1, 0, 1);              // both while empty
    add(1, 0, 1, 8'hC2, 2, 0, 0);
    add(1, 0, 0, 8'hC3, 3, 0, 0);
    add(1, 0, 0, 8'hC4, 4, 0, 0);
    for (int k = 0; k < 20; k++) add(1, 1, 0, 8'(8'hD0 + k), 4, 0, 0);
    for (int k = 3; k >= 0; k--) add(0, 1, 0, 8'h00, k, 0, 0);

    repeat (2) step();
    chk_rst("ua", cnt_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a, q_a);
    chk_rst("ub", cnt_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b, q_b);
    chk_rst("uc", cnt_c, full_c, empty_c, af_c, ae_c, ovf_c, unf_c, q_c);
    arst = 1'b0;
    step();

    // Table-driven run on ua, with data checked through the scoreboard.
    m_cnt = 0;
    foreach (vecs[i]) begin
      w_a = vecs[i].w; r_a = vecs[i].r; c_a = vecs[i].clr; d_a = vecs[i].d;
      wa = vecs[i].w && (m_cnt != 8);
      ra = vecs[i].r && (m_cnt != 0);
      exp_d = 8'h00;
      if (ra) exp_d = sb.pop_front();
      if (wa) sb.push_back(vecs[i].d);
      m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
      step();
      check($sformatf("vec%0d count", i), 32'(cnt_a), 32'(vecs[i].cnt));
      check($sformatf("vec%0d full", i),  32'(full_a), 32'(vecs[i].cnt == 8));
      check($sformatf("vec%0d empty", i), 32'(empty_a), 32'(vecs[i].cnt == 0));
      check($sformatf("vec%0d afull", i), 32'(af_a), 32'(vecs[i].cnt >= 6));
      check($sformatf("vec%0d aempty", i), 32'(ae_a), 32'(vecs[i].cnt <= 2));
      check($sformatf("vec%0d ovf", i),   32'(ovf_a), 32'(vecs[i].ovf));
      check($sformatf("vec%0d unf", i),   32'(unf_a), 32'(vecs[i].unf));
      if (ra) check($sformatf("vec%0d dout", i), 32'(q_a), 32'(exp_d));
    end
    w_a = 0; r_a = 0; c_a = 0;
    check("ua sb drained", 32'(sb.size()), 32'd0);

    // FWFT: the head word shows without r_en, and r_en pops it.
    w_b = 1; d_b = 8'h5A; step(); w_b = 0;
    check("fwft empty after wr", 32'(empty_b), 32'd0);
    check("fwft dout 5A", 32'(q_b), 32'h5A);
    step();
    check("fwft dout hold", 32'(q_b), 32'h5A);
    r_b = 1; step(); r_b = 0;
    check("fwft empty after rd", 32'(empty_b), 32'd1);
    check("fwft dout zero", 32'(q_b), 32'h00);
    for (int k = 1; k <= 3; k++) begin
      w_b = 1; d_b = 8'(8'h11 * k); step();
    end
    w_b = 0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("fwft head%0d", k), 32'(q_b), 32'(8'h11 * k));
      r_b = 1; step(); r_b = 0;
    end
    check("fwft final empty", 32'(empty_b), 32'd1);
    check("fwft final dout", 32'(q_b), 32'h00);
    r_b = 1; step(); r_b = 0;
    check("fwft underflow", 32'(unf_b), 32'd1);

    // Thresholds on uc: step count 0..8..0.
    check("thr c0 aempty", 32'(ae_c), 32'd1);
    check("thr c0 afull", 32'(af_c), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      w_c = 1; d_c = 8'(8'h40 + k); step();
      check($sformatf("thr up%0d aempty", k), 32'(ae_c), 32'(k <= 1));
      check($sformatf("thr up%0d afull", k), 32'(af_c), 32'(k >= 5));
    end
    w_c = 0;
    check("thr full", 32'(full_c), 32'd1);
    for (int k = 7; k >= 0; k--) begin
      r_c = 1; step();
      check($sformatf("thr dn%0d aempty", k), 32'(ae_c), 32'(k <= 1));
      check($sformatf("thr dn%0d afull", k), 32'(af_c), 32'(k >= 5));
      check($sformatf("thr dn%0d dout", k), 32'(q_c), 32'(8'h40 + 8 - k));
    end
    r_c = 0;
    check("thr no ovf", 32'(ovf_c), 32'd0);

    // Reset in the middle of traffic on ua.
    for (int k = 0; k < 5; k++) begin
      w_a = 1; d_a = 8'(8'h60 + k); step();
    end
    w_a = 0;
    check("mid count5", 32'(cnt_a), 32'd5);
    check("mid dout before", 32'(q_a), 32'(8'hD0 + 19));
    arst = 1'b1;
    #1;
    check("mid rst count", 32'(cnt_a), 32'd0);
    check("mid rst empty", 32'(empty_a), 32'd1);
    check("mid rst full", 32'(full_a), 32'd0);
    check("mid rst aempty", 32'(ae_a), 32'd1);
    check("mid rst dout", 32'(q_a), 32'd0);
    step();
    arst = 1'b0;
    w_a = 1; d_a = 8'h77; step(); w_a = 0;
    r_a = 1; step(); r_a = 0;
    check("post rst data", 32'(q_a), 32'h77);
    check("post rst empty", 32'(empty_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
